// File: rtl/seq_busca_pkg.sv
// Shared encodings for the seq_busca fetch/step sequencer.
package seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned STEP_W  = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HALTED = 3'd3;
  localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd4;

  localparam logic [STEP_W-1:0] STEP_0 = 2'd0;
  localparam logic [STEP_W-1:0] STEP_1 = 2'd1;
  localparam logic [STEP_W-1:0] STEP_2 = 2'd2;
  localparam logic [STEP_W-1:0] STEP_3 = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_EXEC   = ST_EXEC,
    S_HALTED = ST_HALTED,
    S_PAUSE  = ST_PAUSE
  } state_e;

endpackage

// File: rtl/seq_busca_contador_passo.sv
// 2-bit execution step counter; clear wins over enable, wraps 11 -> 00.
module contador_passo
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [STEP_W-1:0] step_o
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    step_d = step_q;
    if (clr_i) begin
      step_d = STEP_0;
    end else if (en_i) begin
      step_d = step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_q <= STEP_0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/seq_busca.sv
// Fetch/step sequencer: owns the PC, fetches over req/ack, sequences 4 exec steps.
// Optional single-step mode (step_go port, PAUSE state) under SEQ_SINGLE_STEP_EN.
module seq_busca
  import seq_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_data,
  output logic [INSTR_W-1:0]  instrucao,
  output logic [STEP_W-1:0]   step,
  input  logic                pc_enable,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  input  logic                halt,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step_go,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted
);

  state_e               state_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 mem_req_q;
  logic                 busy_q;
  logic                 halted_q;
  logic                 step_clr_c;
  logic                 step_en_c;
  logic [STEP_W-1:0]    step_w;
  logic [PC_WIDTH-1:0]  pc_d;

  // Step counter is zeroed on the ack edge and on halt, and counts only in EXEC.
  always_comb begin
    step_clr_c = 1'b0;
    step_en_c  = 1'b0;
    if (state_q == S_FETCH && mem_ack) begin
      step_clr_c = 1'b1;
    end
    if (state_q == S_EXEC) begin
      step_en_c = 1'b1;
      if (halt) begin
        step_clr_c = 1'b1;
      end
    end
  end

  contador_passo u_contador_passo (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (step_clr_c),
    .en_i   (step_en_c),
    .step_o (step_w)
  );

  always_comb begin
    pc_d = pc_q;
    if (pc_enable) begin
      pc_d = pc_load ? pc_target : pc_q + PC_WIDTH'(1);
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  logic step_go_q;
  logic go_rise_c;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_go_q <= 1'b0;
    end else begin
      step_go_q <= step_go;
    end
  end

  assign go_rise_c = step_go & ~step_go_q;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            state_q   <= S_EXEC;
            instr_q   <= mem_data;
            mem_req_q <= 1'b0;
          end
        end
        S_EXEC: begin
          // halt beats any PC update requested in the same cycle
          if (halt) begin
            state_q  <= S_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (step_w == STEP_3) begin
            pc_q <= pc_d;
`ifdef SEQ_SINGLE_STEP_EN
            state_q <= S_PAUSE;
            busy_q  <= 1'b0;
`else
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
`endif
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (go_rise_c) begin
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign instrucao = instr_q;
  assign step      = step_w;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
